// File: rtl/nios_fprint_processor0_0_cpu1_oci_dct_packer_if.sv
// Word handshake between the OCI data-trace packer and the trace FIFO.
// The master offers a packed word and its code count; the slave accepts it with word_ready.
interface nios_fprint_processor0_0_cpu1_oci_dct_packer_if;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic        word_ready;

    modport master (
        output word_valid,
        output word_data,
        output word_count,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  word_count,
        output word_ready
    );
endinterface

// File: rtl/nios_fprint_processor0_0_cpu1_oci_dct_packer.sv
// Packs 2-bit data-trace codes into a 30-bit live buffer.
// Full or flushed buffers are handed to a single-entry valid/ready holding register.
module nios_fprint_processor0_0_cpu1_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        trc_on,
    input  logic        code_valid,
    input  logic [1:0]  code,
    input  logic        flush,
    input  logic        test_ending,
    nios_fprint_processor0_0_cpu1_oci_dct_packer_if.master word_if,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state;
    logic [29:0] hold_data;
    logic [3:0]  hold_count;

    logic        append;
    logic [29:0] next_buffer;
    logic [3:0]  next_count;
    logic        emit;
    logic        drain;
    logic        load;
    logic        drop;

    // Emit decisions are made on the post-append view so the appended code is never lost.
    always_comb begin
        append      = trc_on && code_valid;
        next_buffer = dct_buffer;
        next_count  = dct_count;
        if (append) begin
            next_buffer = {dct_buffer[27:0], code};
            next_count  = dct_count + 4'd1;
        end
        emit  = (next_count == 4'd15) || ((flush || test_ending) && (next_count != 4'd0));
        drain = (state == ST_FULL) && word_if.word_ready;
        load  = emit && ((state == ST_EMPTY) || drain);
        drop  = emit && !load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= 30'd0;
            dct_count  <= 4'd0;
        end else if (emit) begin
            dct_buffer <= 30'd0;
            dct_count  <= 4'd0;
        end else begin
            dct_buffer <= next_buffer;
            dct_count  <= next_count;
        end
    end

    // Word payload keeps its last value after a drain; only the state says whether it is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            hold_data  <= 30'd0;
            hold_count <= 4'd0;
        end else begin
            if (load) begin
                hold_data  <= next_buffer;
                hold_count <= next_count;
            end
            case (state)
                ST_EMPTY: if (load) state <= ST_FULL;
                ST_FULL:  if (drain && !load) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign word_if.word_valid = (state == ST_FULL);
    assign word_if.word_data  = hold_data;
    assign word_if.word_count = hold_count;

endmodule
